// File: rtl/wb_seq_master.sv
// wb_seq_master: walks addresses 0..ADR_LAST with one strobe/ack per address and an incrementing data pattern,
// stalling on the exec addresses for their done flag, with loop mode, stop, and error/timeout abort.
module wb_seq_master #(
  parameter int DATA_W   = 128,
  parameter int ADR_W    = 5,
  parameter int ADR_LAST = 19,
  parameter int CMD_ADR  = 16,
  parameter int DATA_ADR = 19,
  parameter int DATA_INC = 5,
  parameter int TIMEOUT  = 16
) (
  input  logic              wb_clock,
  input  logic              reset,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              loop_i,
  input  logic              we_i,
  input  logic [DATA_W-1:0] seed_i,
  input  logic              ack_i,
  input  logic              error_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              cmd_done_i,
  input  logic              data_done_i,
  output logic              we_o,
  output logic [ADR_W-1:0]  adr_o,
  output logic              strobe_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              timeout_o,
  output logic [ADR_W-1:0]  err_adr_o
);
  localparam logic [1:0] IDLE = 2'd0, BUS = 2'd1, DONE_WAIT = 2'd2, GAP = 2'd3;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_END = CW'(TIMEOUT - 1);
  localparam logic [ADR_W-1:0] LAST_A = ADR_W'(ADR_LAST);
  localparam logic [ADR_W-1:0] CMD_A = ADR_W'(CMD_ADR);
  localparam logic [ADR_W-1:0] DATA_A = ADR_W'(DATA_ADR);
  localparam logic [DATA_W-1:0] INC = DATA_W'(DATA_INC);
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic loop_r, is_cmd, is_data, at_last, flag, abort_err, abort_tmo;
  always_comb begin
    is_cmd = adr_o == CMD_A;
    is_data = adr_o == DATA_A;
    at_last = adr_o == LAST_A;
    flag = (is_cmd && cmd_done_i) || (is_data && data_done_i);
    abort_err = state == BUS && error_i;
    // cnt holds the waiting cycles already spent, so the TIMEOUT-th unanswered cycle aborts
    abort_tmo = cnt == CNT_END && ((state == BUS && !error_i && !ack_i) || (state == DONE_WAIT && !flag));
  end
  always_ff @(posedge wb_clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      loop_r <= 1'b0;
      we_o <= 1'b0;
      adr_o <= '0;
      strobe_o <= 1'b0;
      wb_data_o <= '0;
      rd_data_o <= '0;
      rd_valid_o <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      err_o <= 1'b0;
      timeout_o <= 1'b0;
      err_adr_o <= '0;
    end else begin
      done_o <= 1'b0;
      rd_valid_o <= 1'b0;
      if (abort_err || abort_tmo) begin
        if (abort_err) err_o <= 1'b1;
        else timeout_o <= 1'b1;
        err_adr_o <= adr_o;
        strobe_o <= 1'b0;
        busy_o <= 1'b0;
        done_o <= 1'b1;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (start_i) begin
            we_o <= we_i;
            adr_o <= '0;
            wb_data_o <= seed_i;
            loop_r <= loop_i;
            err_o <= 1'b0;
            timeout_o <= 1'b0;
            busy_o <= 1'b1;
            strobe_o <= 1'b1;
            cnt <= '0;
            state <= BUS;
          end
          BUS: if (ack_i) begin
            strobe_o <= 1'b0;
            if (!we_o) begin
              rd_data_o <= wb_data_i;
              rd_valid_o <= 1'b1;
            end
            cnt <= '0;
            state <= (is_cmd || is_data) ? DONE_WAIT : GAP;
          end else cnt <= cnt + 1'b1;
          DONE_WAIT: if (flag) state <= GAP;
          else cnt <= cnt + 1'b1;
          default: if (stop_i || (at_last && !loop_r)) begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state <= IDLE;
          end else begin
            adr_o <= at_last ? '0 : adr_o + 1'b1;
            wb_data_o <= wb_data_o + INC;
            strobe_o <= 1'b1;
            cnt <= '0;
            state <= BUS;
          end
        endcase
      end
    end
  end
endmodule

// File: doc/wb_seq_master.md
# wb_seq_master

Synthesizable, parametrised Wishbone master sequencer for the SD host controller bench and bring-up path. It replaces free-running stimulus with a handshaked sweep: it walks register addresses 0..ADR_LAST, issues one strobe/ack transaction per address with an incrementing data pattern, and stalls on the command-exec and data-exec addresses until the matching done flag arrives. It adds loop mode, error and timeout abort, and captures read data. It sits between the test controller and the SD host Wishbone slave port.

## Interface
Parameters:
- DATA_W, 128, data bus width
- ADR_W, 5, address width
- ADR_LAST, 19, last address of a sweep (less than 2^ADR_W)
- CMD_ADR, 16, command-exec address; waits for cmd_done_i after ack
- DATA_ADR, 19, data-exec address; waits for data_done_i after ack
- DATA_INC, 5, pattern increment per address
- TIMEOUT, 16, maximum wait cycles for ack or done (at least 1)

Ports:
- wb_clock  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start_i  in  1  begin sweep; sampled only in IDLE
- stop_i  in  1  finish current address, then terminate (loop or single)
- loop_i  in  1  sampled at start; 1 = wrap to address 0 after ADR_LAST
- we_i  in  1  sampled at start; direction for the whole sweep
- seed_i  in  DATA_W  first write data value; sampled at start
- ack_i  in  1  slave acknowledge
- error_i  in  1  slave error
- wb_data_i  in  DATA_W  slave read data
- cmd_done_i  in  1  command execution complete
- data_done_i  in  1  data execution complete
- we_o  out  1  write enable
- adr_o  out  ADR_W  transaction address
- strobe_o  out  1  transaction strobe
- wb_data_o  out  DATA_W  write data
- rd_data_o  out  DATA_W  last captured read data
- rd_valid_o  out  1  one-cycle pulse when rd_data_o updates
- busy_o  out  1  sweep in progress
- done_o  out  1  one-cycle pulse on any termination
- err_o  out  1  sticky: slave error seen; cleared by start
- timeout_o  out  1  sticky: ack/done timeout; cleared by start
- err_adr_o  out  ADR_W  address of the failing transaction

## Operation
- States: IDLE, BUS, DONE_WAIT, GAP. All outputs registered. Reset drives every output to 0 and the state to IDLE, including mid-transaction.
- IDLE with start_i=1: the block loads we_o=we_i, adr_o=0, and wb_data_o=seed_i. It latches loop_i, clears err_o and timeout_o, and sets busy_o=1, strobe_o=1, and state BUS. start_i is ignored outside IDLE.
- BUS with error_i=1: error_i wins over ack_i. The block sets err_o=1, err_adr_o=adr_o, strobe_o=0, busy_o=0, done_o=1, and returns to IDLE.
- BUS with ack_i=1: strobe_o=0. If we_o=0, rd_data_o=wb_data_i and rd_valid_o=1. Next state is DONE_WAIT if adr_o is CMD_ADR or DATA_ADR, otherwise GAP.
- BUS with neither error_i nor ack_i: the wait counter increments. When it reaches TIMEOUT, the block sets timeout_o=1, err_adr_o=adr_o, and terminates as for error. If ack_i is high in the timeout cycle, ack wins.
- DONE_WAIT: waits for cmd_done_i (at CMD_ADR) or data_done_i (at DATA_ADR). If CMD_ADR equals DATA_ADR, either flag satisfies the wait. The flag is sampled only in this state. When it is high, next state is GAP. The same TIMEOUT rule applies, with the counter reset on entry.
- GAP (one cycle, strobe_o=0):
  - If stop_i=1, or adr_o=ADR_LAST with loop off: busy_o=0, done_o=1, go to IDLE.
  - If adr_o=ADR_LAST with loop on: adr_o=0.
  - Otherwise: adr_o=adr_o+1.
  - When continuing, wb_data_o=wb_data_o+DATA_INC (modulo 2^DATA_W, never reset by wrap), strobe_o=1, state BUS.
- ack_i, error_i, and the done inputs are ignored in IDLE and GAP.

## Timing
- start_i is sampled at edge k. At edge k, strobe_o=1 and adr_o=0, visible in cycle k+1.
- Zero-wait slave: strobe_o is high exactly one cycle per address, with an address period of 2 cycles.
- A done address costs at least 3 cycles (BUS, DONE_WAIT, GAP).
- Full sweep with default parameters, ack on first strobe cycle, and done flags already high: 42 cycles from the first strobe to the done_o edge.
- rd_valid_o coincides with strobe_o falling.
- err_o and timeout_o are valid in the same cycle as done_o.

## Test plan
- Single write sweep: seed=0, immediate ack, done flags high -> adr_o 0..19, wb_data_o 0,5,…,95; done_o at cycle 42; err_o=0.
- Read sweep with 3-cycle ack latency: wb_data_i=adr×3 -> 20 rd_valid_o pulses, each rd_data_o matches; strobe_o held 3 cycles per address.
- Loop mode with stop_i asserted during address 5 of the second pass -> adr_o wraps 19→0; wb_data_o continues (seed+100 at the second address 0); terminates after address 5 with done_o.
- Error at address 7 (error_i and ack_i together) -> err_o=1, err_adr_o=7, no rd_valid_o, done_o one cycle later; a new start clears err_o.
- Timeout: cmd_done_i held low -> timeout_o=1, err_adr_o=16 after TIMEOUT cycles in DONE_WAIT; ack with counter at TIMEOUT at another address proceeds normally.
- Reset asserted mid-BUS at address 10 -> all outputs 0 the next cycle; start re-runs from address 0 with a fresh seed.
